// File: rtl/prbs6_checker_if.sv
// Bit-stream input and checker status bundle for prbs6_checker.
// master drives the received stream and counter clear; slave reports lock and errors.
interface prbs6_checker_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             clr_cnt;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_bit, clr_cnt,
        input  locked, err, err_cnt
    );

    modport slave (
        input  in_valid, in_bit, clr_cnt,
        output locked, err, err_cnt
    );
endinterface

// File: rtl/prbs6_checker.sv
// Self-synchronising x^6+x^5+1 PRBS checker / BER monitor; outputs registered, 1-cycle response.
// No backpressure: one bit per valid cycle, invalid cycles hold all state.
module prbs6_checker #(
    parameter int LOCK_CNT    = 12,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    prbs6_checker_if.slave   bus
);
    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state;
    logic [5:0]       hist;
    logic [2:0]       fill_cnt;
    logic [7:0]       match_cnt;
    logic [5:0]       win_cnt;
    logic [5:0]       win_err;
    logic             locked_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic       pred;
    logic       mis;
    logic [6:0] win_err_nxt;
    logic [8:0] match_nxt;

    assign pred        = hist[0] ^ hist[5];
    assign mis         = bus.in_valid && (state == LOCKED) && (bus.in_bit != pred);
    assign win_err_nxt = {1'b0, win_err} + 7'(mis);
    assign match_nxt   = {1'b0, match_cnt} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            hist      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= mis;

            // Clear acts every cycle; an error in the same cycle is the first new count.
            if (bus.clr_cnt) begin
                err_cnt_q <= mis ? CNT_W'(1) : '0;
            end else if (mis && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end

            if (bus.in_valid) begin
                case (state)
                    SEARCH: begin
                        hist <= {hist[4:0], bus.in_bit};
                        if (fill_cnt != 3'd6) begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end else if ((bus.in_bit == pred) && (hist != 6'd0)) begin
                            if (match_nxt == 9'(LOCK_CNT)) begin
                                state     <= LOCKED;
                                locked_q  <= 1'b1;
                                match_cnt <= '0;
                                win_cnt   <= '0;
                                win_err   <= '0;
                            end else begin
                                match_cnt <= match_nxt[7:0];
                            end
                        end else begin
                            // All-zero history is a fixed point of the recurrence and must not lock.
                            match_cnt <= '0;
                        end
                    end

                    LOCKED: begin
                        // Free-running reference: received errors never enter hist.
                        hist <= {hist[4:0], pred};
                        if (mis && (win_err_nxt == 7'(UNLOCK_ERRS))) begin
                            state     <= SEARCH;
                            locked_q  <= 1'b0;
                            fill_cnt  <= '0;
                            match_cnt <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else if (win_cnt == 6'd62) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + 6'd1;
                            win_err <= win_err_nxt[5:0];
                        end
                    end

                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign bus.locked  = locked_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_prbs6_checker.sv
// Directed bench for prbs6_checker: lock, error detection, unlock/relock, counters, gapped input.
module tb_prbs6_checker;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prbs6_checker_if #(.CNT_W(16)) bus ();
    prbs6_checker_if #(.CNT_W(4))  bus4 ();

    prbs6_checker #(.LOCK_CNT(12), .UNLOCK_ERRS(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    prbs6_checker #(.LOCK_CNT(12), .UNLOCK_ERRS(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4));

    logic seq [63];
    int   gi;
    int   win_base;
    int   hits;
    int   stray;
    int   nflip;
    int   lock_at;
    int   vcount;
    int   any_lock;
    int   lost;
    int   cnt_assert = 0;
    int   cnt_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cnt_assert++;
        assert (obs === exp) else begin
            cnt_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs to both instances; return 1 ns after the sampling edge.
    task automatic drive(input logic v, input logic b, input logic c);
        @(negedge clk);
        bus.in_valid  = v;  bus.in_bit  = b;  bus.clr_cnt  = c;
        bus4.in_valid = v;  bus4.in_bit = b;  bus4.clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic flip, input logic c);
        drive(1'b1, seq[gi % 63] ^ flip, c);
        gi++;
        if (bus.err && flip)  hits++;
        if (bus.err && !flip) stray++;
        if (!bus.locked)      lost = 1;
    endtask

    task automatic to_window_start();
        while (((gi - win_base) % 63) != 0) send(1'b0, 1'b0);
    endtask

    initial begin
        int p;
        logic f;
        for (int i = 0; i < 6; i++) seq[i] = (i == 5);
        for (int i = 6; i < 63; i++) seq[i] = seq[i-1] ^ seq[i-6];

        rst_n = 1'b0;
        bus.in_valid = 0;  bus.in_bit = 0;  bus.clr_cnt = 0;
        bus4.in_valid = 0; bus4.in_bit = 0; bus4.clr_cnt = 0;
        gi = 0; hits = 0; stray = 0; lost = 0; win_base = 0;
        #12;
        chk("reset_locked", 32'(bus.locked), 0);
        chk("reset_err", 32'(bus.err), 0);
        chk("reset_err_cnt", 32'(bus.err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean stream from seed 000001: lock on the 18th bit.
        for (int i = 0; i < 17; i++) send(1'b0, 1'b0);
        chk("lock_after_17", 32'(bus.locked), 0);
        send(1'b0, 1'b0);
        chk("lock_after_18", 32'(bus.locked), 1);
        win_base = gi;
        stray = 0;
        for (int i = 0; i < 482; i++) send(1'b0, 1'b0);
        chk("clean_500_err_pulses", 32'(stray), 0);
        chk("clean_500_err_cnt", 32'(bus.err_cnt), 0);
        chk("clean_500_locked", 32'(bus.locked), 1);

        // Single inverted bit.
        send(1'b1, 1'b0);
        chk("single_err_pulse", 32'(bus.err), 1);
        chk("single_err_cnt", 32'(bus.err_cnt), 1);
        chk("single_locked", 32'(bus.locked), 1);
        stray = 0;
        for (int i = 0; i < 30; i++) send(1'b0, 1'b0);
        chk("single_no_followon", 32'(stray), 0);
        chk("single_err_cnt_hold", 32'(bus.err_cnt), 1);

        // Clear on an invalid cycle, then 3 errors per window over 5 windows.
        drive(1'b0, 1'b0, 1'b1);
        chk("clr_cnt_zero", 32'(bus.err_cnt), 0);
        to_window_start();
        hits = 0; stray = 0; lost = 0;
        for (int i = 0; i < 5 * 63; i++) begin
            p = (gi - win_base) % 63;
            send((p == 10) || (p == 30) || (p == 50), 1'b0);
        end
        chk("three_per_win_hits", 32'(hits), 15);
        chk("three_per_win_stray", 32'(stray), 0);
        chk("three_per_win_err_cnt", 32'(bus.err_cnt), 15);
        chk("three_per_win_no_unlock", 32'(lost), 0);

        // Four errors in one window force unlock on the 4th.
        drive(1'b0, 1'b0, 1'b1);
        to_window_start();
        for (int q = 0; q <= 35; q++) begin
            send((q == 5) || (q == 15) || (q == 25) || (q == 35), 1'b0);
            if (q == 25) chk("unlock_hold_after_3", 32'(bus.locked), 1);
        end
        chk("unlock_err_pulse", 32'(bus.err), 1);
        chk("unlock_locked_low", 32'(bus.locked), 0);
        chk("unlock_err_cnt", 32'(bus.err_cnt), 4);
        stray = 0;
        for (int i = 0; i < 17; i++) send(1'b0, 1'b0);
        chk("relock_after_17", 32'(bus.locked), 0);
        send(1'b0, 1'b0);
        chk("relock_after_18", 32'(bus.locked), 1);
        chk("relock_no_err", 32'(stray), 0);
        win_base = gi;

        // clr_cnt coincident with an error.
        send(1'b1, 1'b1);
        chk("clr_with_err_pulse", 32'(bus.err), 1);
        chk("clr_with_err_cnt", 32'(bus.err_cnt), 1);

        // 20 errors: wide counter reads 20, 4-bit counter saturates at 15.
        drive(1'b0, 1'b0, 1'b1);
        to_window_start();
        hits = 0; nflip = 0; lost = 0;
        while (nflip < 20) begin
            p = (gi - win_base) % 63;
            f = (p == 10) || (p == 30) || (p == 50);
            send(f, 1'b0);
            if (f) nflip++;
        end
        chk("sat_hits", 32'(hits), 20);
        chk("sat_wide_err_cnt", 32'(bus.err_cnt), 20);
        chk("sat_narrow_err_cnt", 32'(bus4.err_cnt), 15);
        chk("sat_no_unlock", 32'(lost), 0);

        // Asynchronous reset while locked with err high.
        send(1'b1, 1'b0);
        chk("pre_reset_err", 32'(bus.err), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_locked", 32'(bus.locked), 0);
        chk("async_rst_err", 32'(bus.err), 0);
        chk("async_rst_err_cnt", 32'(bus.err_cnt), 0);
        chk("async_rst_err_cnt4", 32'(bus4.err_cnt), 0);

        // All-zero input never locks.
        @(negedge clk);
        rst_n = 1'b1;
        any_lock = 0; stray = 0;
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            if (bus.locked) any_lock = 1;
            if (bus.err)    stray++;
        end
        chk("zeros_no_lock", 32'(any_lock), 0);
        chk("zeros_no_err", 32'(stray), 0);

        // Gapped clean stream: lock point counted in valid bits.
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        gi = 0; vcount = 0; lock_at = -1; stray = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                drive(1'b1, seq[gi % 63], 1'b0);
                gi++;
                vcount++;
            end else begin
                drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            if (bus.locked && (lock_at < 0)) lock_at = vcount;
            if (bus.err) stray++;
        end
        chk("gapped_lock_point", 32'(lock_at), 18);
        chk("gapped_no_err", 32'(stray), 0);
        chk("gapped_err_cnt", 32'(bus.err_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", cnt_assert, cnt_fail);
        $finish;
    end
endmodule
